alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
Registered WIDTH-bit integer ALU with 4-bit opcode, producing a result plus carry, zero, negative and overflow flags. Operands are sampled and the outputs registered on each rising clock edge. Sits in the datapath execute stage, fed by a register file or operand muxes.

Parameters:
WIDTH, 4, operand/result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  4  operation select
result  output  WIDTH  registered result
carry_flag  output  1  registered carry/borrow/shifted-out bit
zero_flag  output  1  registered, 1 when result == 0
negative_flag  output  1  registered, result MSB
overflow_flag  output  1  registered signed/width overflow

Behaviour:
- One clock; reset is synchronous and active-high. With rst=1 at a rising edge, result and all flags become 0; reset overrides any opcode in that cycle.
- Latency 1 cycle: outputs at edge N reflect a/b/opcode sampled at edge N. No handshake; every cycle computes.
- zero_flag = (result==0) and negative_flag = result[WIDTH-1] for all opcodes, including reserved ones.
- Unless stated otherwise below, carry=0 and overflow=0.
- 0000 ADD: result = (a+b) mod 2^WIDTH. carry = bit WIDTH of the unsigned sum. overflow = signed two's-complement overflow (operand signs equal, result sign differs).
- 0001 SUB: result = (a−b) mod 2^WIDTH. carry = borrow (1 when a<b unsigned). overflow = signed overflow (operand signs differ, result sign differs from a).
- 0010 AND, 0011 OR, 0111 XOR: bitwise.
- 0100 NOT: result = ~a.
- 0101 MUL: unsigned product truncated to low WIDTH bits. carry = overflow = 1 when any upper WIDTH bits of the 2·WIDTH product are nonzero.
- 0110 DIV: unsigned quotient a/b.
  - b==0: result = all ones, overflow=1, carry=0.
- 1000 LSL: a<<1, zero-filled; carry = a[WIDTH-1].
- 1001 LSR: a>>1, zero-filled; carry = a[0].
- 1010 ASR: a>>1, MSB replicated; carry = a[0].
- 1011 ROL: {a[WIDTH-2:0],a[WIDTH-1]}; carry = a[WIDTH-1].
- 1100 ROR: {a[0],a[WIDTH-1:1]}; carry = a[0].
- 1101 ASL: same result and carry as LSL; overflow = a[WIDTH-1] XOR a[WIDTH-2] (sign changed).
- 1111 PASS: result = a.
- 1110 reserved: result=0, carry=0, overflow=0, so zero_flag=1.
- Shift amount is always 1; b is ignored for NOT, PASS and all shifts/rotates.

Optional Feature:
ALU_MULDIV_EN: when defined, MUL (0101) and DIV (0110) behave as above. When undefined, no multiplier/divider is synthesised and 0101/0110 behave as reserved (result=0, carry=0, overflow=0, zero=1).

Decomposition:
- Package alu_pkg: 4-bit opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_MUL, OP_DIV, OP_XOR, OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_ASL, OP_PASS) and a flags struct {carry, zero, negative, overflow}.
- One natural sub-module: alu_shifter, combinational; handles LSL/LSR/ASR/ROL/ROR/ASL and returns result, carry and overflow.
- Top level: arithmetic/logic mux plus the output register.

Test Plan:
- Reset/latency: rst=1 with a=7, b=8, ADD → next edge all outputs 0. Release rst → one edge later result=15, negative=1, carry=0, overflow=0. Assert rst mid-stream → outputs 0 on that edge.
- ADD 8+8 → result=0, carry=1, zero=1, overflow=1. ADD 7+8 → 15, negative=1, overflow=0.
- SUB 5−5 → 0, zero=1, carry=0. SUB 8−10 → 14, carry=1, negative=1, overflow=0. SUB 9−5 → 4, overflow=1, carry=0.
- Logic:
  - AND 0xA&0xC → 8.
  - OR 0xC|0x3 → 15.
  - XOR 0xF^0x0 → 15.
  - NOT 0xC → 3.
  - PASS 9 → 9, negative=1.
  - Opcode 1110 → 0, zero=1.
- MUL/DIV (ALU_MULDIV_EN defined):
  - 3*4 → 12, carry=0.
  - 8*4 → 0, carry=1, overflow=1, zero=1.
  - 9/3 → 3.
  - 5/0 → 15, overflow=1.
  - With the macro undefined, 3*4 → 0, zero=1.
- Shifts:
  - LSL 0101 → 1010, carry=0.
  - LSR 1010 → 0101, carry=0.
  - ASR 1010 → 1101, carry=0.
  - ROL 1001 → 0011, carry=1.
  - ROR 1001 → 1100, carry=1.
  - ASL 0101 → 1010, overflow=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the registered integer ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_ASL  = 4'b1101;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Single-bit shift/rotate unit; result, shifted-out bit and ASL sign-change flag.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_LSL: begin
        result_o = {a_i[WIDTH-2:0], 1'b0};
        carry_o  = a_i[WIDTH-1];
      end
      OP_LSR: begin
        result_o = {1'b0, a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      OP_ASR: begin
        result_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      OP_ROL: begin
        result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        carry_o  = a_i[WIDTH-1];
      end
      OP_ROR: begin
        result_o = {a_i[0], a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      OP_ASL: begin
        // Sign changes exactly when the top two bits differ before the shift.
        result_o   = {a_i[WIDTH-2:0], 1'b0};
        carry_o    = a_i[WIDTH-1];
        overflow_o = a_i[WIDTH-1] ^ a_i[WIDTH-2];
      end
      default: begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Registered WIDTH-bit ALU: operation mux plus output/flag register.
// Define ALU_MULDIV_EN to build the multiplier and divider; otherwise MUL/DIV act as reserved.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag
);

  logic [WIDTH-1:0] result_d, result_q;
  alu_flags_t       flags_d, flags_q;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] shf_result;
  logic             shf_carry, shf_overflow;
  logic             carry_d, overflow_d;

`ifdef ALU_MULDIV_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a_i        (a),
    .op_i       (opcode),
    .result_o   (shf_result),
    .carry_o    (shf_carry),
    .overflow_o (shf_overflow)
  );

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (opcode)
      OP_ADD: begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (a < b unsigned).
        result_d   = diff[WIDTH-1:0];
        carry_d    = diff[WIDTH];
        overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_NOT:  result_d = ~a;
      OP_PASS: result_d = a;
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        result_d   = prod[WIDTH-1:0];
        carry_d    = |prod[2*WIDTH-1:WIDTH];
        overflow_d = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b == '0) begin
          result_d   = '1;
          overflow_d = 1'b1;
        end else begin
          result_d = a / b;
        end
      end
`endif
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_ASL: begin
        result_d   = shf_result;
        carry_d    = shf_carry;
        overflow_d = shf_overflow;
      end
      default: begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags_d          = '0;
    flags_d.carry    = carry_d;
    flags_d.zero     = (result_d == '0);
    flags_d.negative = result_d[WIDTH-1];
    flags_d.overflow = overflow_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result        = result_q;
  assign carry_flag    = flags_q.carry;
  assign zero_flag     = flags_q.zero;
  assign negative_flag = flags_q.negative;
  assign overflow_flag = flags_q.overflow;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core (WIDTH=4); expected {result,c,z,n,v} are hand-computed.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, opcode;
  logic [3:0] result;
  logic       carry_flag, zero_flag, negative_flag, overflow_flag;

  int n_checks = 0;
  int n_fails  = 0;

  alu_core #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .a             (a),
    .b             (b),
    .opcode        (opcode),
    .result        (result),
    .carry_flag    (carry_flag),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got {res,c,z,n,v}=%b_%b required %b_%b",
               tag, obs[7:4], obs[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // Drive one vector, clock it in, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp);
    rst    = r;
    opcode = op;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
    check_out(tag, {result, carry_flag, zero_flag, negative_flag, overflow_flag}, exp);
  endtask

  initial begin
    rst = 1'b1; opcode = 4'b0000; a = 4'd7; b = 4'd8;

    step("reset_add",   1'b1, 4'b0000, 4'd7,  4'd8,  8'b0000_0000);
    step("add_7_8",     1'b0, 4'b0000, 4'd7,  4'd8,  8'b1111_0010);
    step("add_8_8",     1'b0, 4'b0000, 4'd8,  4'd8,  8'b0000_1101);
    step("rst_mid",     1'b1, 4'b0000, 4'd7,  4'd8,  8'b0000_0000);
    step("sub_5_5",     1'b0, 4'b0001, 4'd5,  4'd5,  8'b0000_0100);
    step("sub_8_10",    1'b0, 4'b0001, 4'd8,  4'd10, 8'b1110_1010);
    step("sub_9_5",     1'b0, 4'b0001, 4'd9,  4'd5,  8'b0100_0001);
    step("and_a_c",     1'b0, 4'b0010, 4'hA,  4'hC,  8'b1000_0010);
    step("or_c_3",      1'b0, 4'b0011, 4'hC,  4'h3,  8'b1111_0010);
    step("xor_f_0",     1'b0, 4'b0111, 4'hF,  4'h0,  8'b1111_0010);
    step("not_c",       1'b0, 4'b0100, 4'hC,  4'h5,  8'b0011_0000);
    step("pass_9",      1'b0, 4'b1111, 4'd9,  4'd6,  8'b1001_0010);
    step("rsvd_1110",   1'b0, 4'b1110, 4'hF,  4'hF,  8'b0000_0100);
`ifdef ALU_MULDIV_EN
    step("mul_3_4",     1'b0, 4'b0101, 4'd3,  4'd4,  8'b1100_0010);
    step("mul_8_4",     1'b0, 4'b0101, 4'd8,  4'd4,  8'b0000_1101);
    step("div_9_3",     1'b0, 4'b0110, 4'd9,  4'd3,  8'b0011_0000);
    step("div_5_0",     1'b0, 4'b0110, 4'd5,  4'd0,  8'b1111_0011);
`else
    step("mul_3_4_off", 1'b0, 4'b0101, 4'd3,  4'd4,  8'b0000_0100);
    step("mul_8_4_off", 1'b0, 4'b0101, 4'd8,  4'd4,  8'b0000_0100);
    step("div_9_3_off", 1'b0, 4'b0110, 4'd9,  4'd3,  8'b0000_0100);
    step("div_5_0_off", 1'b0, 4'b0110, 4'd5,  4'd0,  8'b0000_0100);
`endif
    step("lsl_0101",    1'b0, 4'b1000, 4'b0101, 4'hF, 8'b1010_0010);
    step("lsl_1000",    1'b0, 4'b1000, 4'b1000, 4'h3, 8'b0000_1100);
    step("lsr_1010",    1'b0, 4'b1001, 4'b1010, 4'h7, 8'b0101_0000);
    step("asr_1010",    1'b0, 4'b1010, 4'b1010, 4'h1, 8'b1101_0010);
    step("rol_1001",    1'b0, 4'b1011, 4'b1001, 4'h2, 8'b0011_1000);
    step("ror_1001",    1'b0, 4'b1100, 4'b1001, 4'h4, 8'b1100_1010);
    step("asl_0101",    1'b0, 4'b1101, 4'b0101, 4'h8, 8'b1010_0011);
    step("asl_0011",    1'b0, 4'b1101, 4'b0011, 4'h9, 8'b0110_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
